// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: holds, flushes and bubbles for the five-stage core,
// HALT drain/freeze sequencing and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_rs_vld,
    input  logic                id_rt_vld,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_rd_wr,
    input  logic                ex_is_load,
    input  logic                br_taken_ex,
    input  logic                imem_busy,
    input  logic                mem_busy,
    input  logic                halt_id,
    output logic                stall_pc,
    output logic                stall_ifid,
    output logic                stall_idex,
    output logic                stall_exmem,
    output logic                stall_memwb,
    output logic                flush_ifid,
    output logic                bubble_idex,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [CNT_BITS-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic st_pc, st_ifid, st_idex, st_exmem, st_memwb, fl_ifid, bub_idex;

    assign load_use = ex_is_load & ex_rd_wr &
                      ((id_rs_vld & (id_rs == ex_rd)) | (id_rt_vld & (id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        st_pc       = 1'b0;
        st_ifid     = 1'b0;
        st_idex     = 1'b0;
        st_exmem    = 1'b0;
        st_memwb    = 1'b0;
        fl_ifid     = 1'b0;
        bub_idex    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    st_pc    = 1'b1;
                    st_ifid  = 1'b1;
                    st_idex  = 1'b1;
                    st_exmem = 1'b1;
                    st_memwb = 1'b1;
                end else if (br_taken_ex) begin
                    fl_ifid  = 1'b1;
                    bub_idex = 1'b1;
                end else if (load_use) begin
                    st_pc    = 1'b1;
                    st_ifid  = 1'b1;
                    bub_idex = 1'b1;
                end else if (imem_busy) begin
                    st_pc   = 1'b1;
                    fl_ifid = 1'b1;
                end else if (halt_id) begin
                    st_pc       = 1'b1;
                    fl_ifid     = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd3;
                end
            end
            ST_DRAIN: begin
                st_pc   = 1'b1;
                fl_ifid = 1'b1;
                if (mem_busy) begin
                    st_ifid  = 1'b1;
                    st_idex  = 1'b1;
                    st_exmem = 1'b1;
                    st_memwb = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                    // A zero count is unreachable; treat it like the last step so we never wrap.
                    if (drain_cnt_q <= 2'd1) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                st_pc    = 1'b1;
                st_ifid  = 1'b1;
                st_idex  = 1'b1;
                st_exmem = 1'b1;
                st_memwb = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 2'd0;
            end
        endcase
    end

    // Outputs are forced low for the whole time rst is held.
    always_comb begin
        stall_pc    = st_pc    & ~rst;
        stall_ifid  = st_ifid  & ~rst;
        stall_idex  = st_idex  & ~rst;
        stall_exmem = st_exmem & ~rst;
        stall_memwb = st_memwb & ~rst;
        flush_ifid  = fl_ifid  & ~rst;
        bubble_idex = bub_idex & ~rst;
        halted      = (state_q == ST_HALTED) & ~rst;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_pc && (state_q != ST_HALTED) && (stall_cycles_q != {CNT_BITS{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            drain_cnt_q    <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: combinational priority table plus multi-cycle
// sequences for load-use, imem stall, HALT drain, reset mid-drain and counter saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_rs_vld = 1'b0, id_rt_vld = 1'b0, ex_rd_wr = 1'b0, ex_is_load = 1'b0;
    logic       br_taken_ex = 1'b0, imem_busy = 1'b0, mem_busy = 1'b0, halt_id = 1'b0;

    logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic        flush_ifid, bubble_idex, halted;
    logic [15:0] stall_cycles;

    logic        s4_pc, s4_ifid, s4_idex, s4_exmem, s4_memwb, f4_ifid, b4_idex, h4;
    logic [3:0]  stall_cycles4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_BITS(3), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr), .ex_is_load(ex_is_load),
        .br_taken_ex(br_taken_ex), .imem_busy(imem_busy), .mem_busy(mem_busy),
        .halt_id(halt_id),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
        .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.REG_BITS(3), .CNT_BITS(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr), .ex_is_load(ex_is_load),
        .br_taken_ex(br_taken_ex), .imem_busy(imem_busy), .mem_busy(mem_busy),
        .halt_id(halt_id),
        .stall_pc(s4_pc), .stall_ifid(s4_ifid), .stall_idex(s4_idex),
        .stall_exmem(s4_exmem), .stall_memwb(s4_memwb),
        .flush_ifid(f4_ifid), .bubble_idex(b4_idex),
        .halted(h4), .stall_cycles(stall_cycles4)
    );

    // {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_ifid, bubble_idex}
    logic [6:0] outs;
    assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_ifid, bubble_idex};

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100001;
    localparam logic [6:0] O_BR    = 7'b0000011;
    localparam logic [6:0] O_MEM   = 7'b1111100;
    localparam logic [6:0] O_IMEM  = 7'b1000010;
    localparam logic [6:0] O_DRMEM = 7'b1111110;

    typedef struct {
        logic       ld, wr;
        logic [2:0] rd, rs, rt;
        logic       rsv, rtv, br, imem, mem, halt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_rs_vld = 1'b0; id_rt_vld = 1'b0; ex_rd_wr = 1'b0; ex_is_load = 1'b0;
        br_taken_ex = 1'b0; imem_busy = 1'b0; mem_busy = 1'b0; halt_id = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_lu(input logic [2:0] rd, input logic [2:0] rs);
        ex_is_load = 1'b1; ex_rd_wr = 1'b1; ex_rd = rd; id_rs = rs; id_rs_vld = 1'b1;
    endtask

    initial begin
        //          ld  wr  rd    rs    rt    rsv rtv br  imem mem halt exp
        vecs[0]  = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, O_NONE};
        vecs[1]  = '{1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, O_LU};
        vecs[2]  = '{1, 1, 3'd3, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0, O_NONE};
        vecs[3]  = '{1, 1, 3'd5, 3'd1, 3'd5, 0, 1, 0, 0, 0, 0, O_LU};
        vecs[4]  = '{1, 1, 3'd0, 3'd0, 3'd4, 1, 0, 0, 0, 0, 0, O_LU};
        vecs[5]  = '{1, 0, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, O_NONE};
        vecs[6]  = '{0, 1, 3'd3, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, O_NONE};
        vecs[7]  = '{1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 0, 0, 0, O_BR};
        vecs[8]  = '{1, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 0, 1, 0, O_MEM};
        vecs[9]  = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, O_IMEM};
        vecs[10] = '{1, 1, 3'd6, 3'd6, 3'd0, 1, 0, 0, 1, 0, 1, O_LU};
        vecs[11] = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 1, O_BR};
        vecs[12] = '{0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 1, O_MEM};
        vecs[13] = '{1, 1, 3'd3, 3'd2, 3'd7, 1, 1, 0, 0, 0, 0, O_NONE};

        // Reset values and outputs forced low while rst is held
        #1;
        chk("rst_outs", {25'd0, outs}, {25'd0, O_NONE});
        chk("rst_cnt", {16'd0, stall_cycles}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        do_reset();

        // Table: none of these vectors leave RUN, so they can be applied back to back
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ex_is_load = vecs[i].ld; ex_rd_wr = vecs[i].wr; ex_rd = vecs[i].rd;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_rs_vld = vecs[i].rsv; id_rt_vld = vecs[i].rtv;
            br_taken_ex = vecs[i].br; imem_busy = vecs[i].imem;
            mem_busy = vecs[i].mem; halt_id = vecs[i].halt;
            #1;
            chk($sformatf("vec%0d", i), {25'd0, outs}, {25'd0, vecs[i].exp});
            chk($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
        end

        // Load-use stalls for one cycle; the bubble then clears ex_is_load
        do_reset();
        set_lu(3'd3, 3'd3);
        #1;
        chk("lu_cycle0", {25'd0, outs}, {25'd0, O_LU});
        @(negedge clk);
        ex_is_load = 1'b0; ex_rd_wr = 1'b0;
        #1;
        chk("lu_released", {25'd0, outs}, {25'd0, O_NONE});
        chk("lu_cnt", {16'd0, stall_cycles}, 32'd1);

        // imem_busy for 4 cycles
        do_reset();
        chk("imem_cnt0", {16'd0, stall_cycles}, 32'd0);
        imem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("imem_c%0d", i), {25'd0, outs}, {25'd0, O_IMEM});
            @(negedge clk);
        end
        imem_busy = 1'b0;
        #1;
        chk("imem_cnt4", {16'd0, stall_cycles}, 32'd4);
        chk("imem_after", {25'd0, outs}, {25'd0, O_NONE});

        // HALT drain with two mem_busy cycles: halted at N+6
        do_reset();
        halt_id = 1'b1;                                   // cycle N
        #1;
        chk("halt_n", {25'd0, outs}, {25'd0, O_IMEM});
        @(negedge clk);                                   // N+1, DRAIN cnt=3
        halt_id = 1'b0; br_taken_ex = 1'b1; set_lu(3'd2, 3'd2);
        #1;
        chk("drain_n1", {25'd0, outs}, {25'd0, O_IMEM});
        chk("drain_n1_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);                                   // N+2, cnt=2
        br_taken_ex = 1'b0; ex_is_load = 1'b0; mem_busy = 1'b1;
        #1;
        chk("drain_n2_mem", {25'd0, outs}, {25'd0, O_DRMEM});
        @(negedge clk);                                   // N+3, cnt=2
        #1;
        chk("drain_n3_mem", {25'd0, outs}, {25'd0, O_DRMEM});
        @(negedge clk);                                   // N+4, cnt=2
        mem_busy = 1'b0;
        #1;
        chk("drain_n4", {25'd0, outs}, {25'd0, O_IMEM});
        @(negedge clk);                                   // N+5, cnt=1
        #1;
        chk("drain_n5_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);                                   // N+6
        br_taken_ex = 1'b1; imem_busy = 1'b1;
        #1;
        chk("halted_n6", {31'd0, halted}, 32'd1);
        chk("halted_outs", {25'd0, outs}, {25'd0, O_MEM});
        chk("halt_cnt", {16'd0, stall_cycles}, 32'd6);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("halted_sticky", {31'd0, halted}, 32'd1);
        chk("halted_cnt_frozen", {16'd0, stall_cycles}, 32'd6);

        // Reset mid-DRAIN with stall_cycles=5
        do_reset();
        halt_id = 1'b1;                                   // N
        @(negedge clk);
        halt_id = 1'b0;                                   // N+1
        @(negedge clk);
        mem_busy = 1'b1;                                  // N+2..N+5 held in DRAIN
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_cnt", {16'd0, stall_cycles}, 32'd5);
        chk("pre_rst_outs", {25'd0, outs}, {25'd0, O_DRMEM});
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {25'd0, outs}, {25'd0, O_NONE});
        chk("mid_rst_cnt", {16'd0, stall_cycles}, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        br_taken_ex = 1'b1;
        #1;
        chk("post_rst_run", {25'd0, outs}, {25'd0, O_BR});
        chk("post_rst_cnt", {16'd0, stall_cycles}, 32'd0);

        // Saturation on the 4-bit instance
        do_reset();
        imem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 14) begin
                #1;
                chk("sat_at15", {28'd0, stall_cycles4}, 32'd15);
            end
        end
        imem_busy = 1'b0;
        #1;
        chk("sat_cnt4", {28'd0, stall_cycles4}, 32'd15);
        chk("sat_cnt16", {16'd0, stall_cycles}, 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
